// File: rtl/rf_wr_arbiter.sv
// Two-requester arbiter for the register-file write port: pipeline-first, with a starvation
// escape and a lock mode for interrupt context-restore bursts. Writes are registered, one cycle after accept.
module rf_wr_arbiter #(
   parameter int DW         = 16,
   parameter int AW         = 3,
   parameter int STARVE_LIM = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p_valid,
   output logic          p_ready,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_data,
   input  logic          i_valid,
   output logic          i_ready,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_data,
   input  logic          i_lock,
   input  logic          i_last,
   output logic          rf_we,
   output logic [AW-1:0] rf_addr,
   output logic [DW-1:0] rf_data,
   output logic          locked
);
   localparam int CW = $clog2(STARVE_LIM + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

   typedef enum logic {ARB, LOCK} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] starve_cnt, starve_nxt;
   logic          i_force;

   always_comb begin
      p_ready    = 1'b0;
      i_ready    = 1'b0;
      i_force    = 1'b0;
      state_nxt  = state;
      starve_nxt = starve_cnt;
      case (state)
         ARB: begin
            i_force = i_valid && (starve_cnt == LIM);
            p_ready = p_valid && !i_force;
            i_ready = i_valid && !p_ready;
            if (!i_valid || i_ready)
               starve_nxt = '0;
            else if (starve_cnt != LIM)
               starve_nxt = starve_cnt + 1'b1;
            if (i_ready && i_lock && !i_last)
               state_nxt = LOCK;
         end
         LOCK: begin
            i_ready    = i_valid;
            starve_nxt = '0;
            // Dropping i_lock releases the port even without a beat.
            if ((i_ready && i_last) || !i_lock)
               state_nxt = ARB;
         end
         default: state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB;
         starve_cnt <= '0;
         rf_we      <= 1'b0;
         rf_addr    <= '0;
         rf_data    <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         rf_we      <= 1'b0;
         if (p_ready) begin
            rf_we   <= (p_addr != '0);
            rf_addr <= p_addr;
            rf_data <= p_data;
         end else if (i_ready) begin
            rf_we   <= (i_addr != '0);
            rf_addr <= i_addr;
            rf_data <= i_data;
         end
      end
   end

   assign locked = (state == LOCK);
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Randomized + directed bench for rf_wr_arbiter: a driver checks ready/locked against a
// behavioural model and queues expected rf_* values; a monitor pops and compares every cycle.
module tb_rf_wr_arbiter;
   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        p_valid, p_ready, i_valid, i_ready, i_lock, i_last;
   logic [2:0]  p_addr, i_addr, rf_addr;
   logic [15:0] p_data, i_data, rf_data;
   logic        rf_we, locked;

   rf_wr_arbiter #(.DW(16), .AW(3), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rst(rst),
      .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr), .p_data(p_data),
      .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_data(i_data),
      .i_lock(i_lock), .i_last(i_last),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .locked(locked)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [2:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   drv_done = 1'b0;

   // Reference model state: lock mode, cycles I has waited, last written address/data.
   bit          m_lock = 1'b0;
   int          m_wait = 0;
   logic [2:0]  m_addr = '0;
   logic [15:0] m_data = '0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic cycle(input bit r, input bit pv, input logic [2:0] pa, input logic [15:0] pd,
                        input bit iv, input logic [2:0] ia, input logic [15:0] id,
                        input bit il, input bit ilst, output bit p_acc, output bit i_acc);
      bit   ep, ei;
      exp_t e;
      @(negedge clk);
      rst = r; p_valid = pv; p_addr = pa; p_data = pd;
      i_valid = iv; i_addr = ia; i_data = id; i_lock = il; i_last = ilst;
      #1;
      if (m_lock) begin
         ep = 1'b0;
         ei = iv;
      end else begin
         ep = pv && !(iv && m_wait >= LIM);
         ei = iv && !ep;
      end
      if (!r) begin
         chk("p_ready", int'(p_ready), int'(ep));
         chk("i_ready", int'(i_ready), int'(ei));
         chk("locked", int'(locked), int'(m_lock));
      end
      p_acc = ep && !r;
      i_acc = ei && !r;
      if (r) begin
         m_lock = 1'b0; m_wait = 0; m_addr = '0; m_data = '0;
         e = '{we: 1'b0, addr: 3'd0, data: 16'd0};
      end else begin
         e.we = 1'b0;
         if (ep) begin
            m_addr = pa; m_data = pd; e.we = (pa != 0);
         end else if (ei) begin
            m_addr = ia; m_data = id; e.we = (ia != 0);
         end
         e.addr = m_addr;
         e.data = m_data;
         if (m_lock) begin
            m_wait = 0;
            if ((ei && ilst) || !il) m_lock = 1'b0;
         end else begin
            if (ei && il && !ilst) m_lock = 1'b1;
            if (ei || !iv) m_wait = 0;
            else if (m_wait < LIM) m_wait++;
         end
      end
      q.push_back(e);
   endtask

   // Monitor: registered outputs are compared once per cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rf_we", int'(rf_we), int'(e.we));
            chk("rf_addr", int'(rf_addr), int'(e.addr));
            chk("rf_data", int'(rf_data), int'(e.data));
         end
      end
   end

   initial begin
      bit pa_, ia_;
      int n;
      bit          pv, iv, il, ilst, p_pend, i_pend, r;
      logic [2:0]  pa, ia;
      logic [15:0] pd, id;
      int          i_bl;

      rst = 1'b1; p_valid = 0; p_addr = 0; p_data = 0;
      i_valid = 0; i_addr = 0; i_data = 0; i_lock = 0; i_last = 0;
      for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, pa_, ia_);
      @(negedge clk); #1;
      chk("reset_locked", int'(locked), 0);
      chk("reset_rf_we", int'(rf_we), 0);

      // P alone, then an r0 write
      cycle(0, 1, 3'd3, 16'hBEEF, 0, 0, 0, 0, 0, pa_, ia_);
      chk("p_alone_acc", int'(pa_), 1);
      cycle(0, 1, 3'd0, 16'h1234, 0, 0, 0, 0, 0, pa_, ia_);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, pa_, ia_);

      // Contention: 4:1 pattern
      for (int k = 0; k < 10; k++) begin
         cycle(0, 1, 3'd2, 16'(k), 1, 3'd5, 16'hA000 + 16'(k / 5), 0, 0, pa_, ia_);
         chk("contend_p_wins", int'(pa_), int'(k % 5 != 4));
      end

      // Locked burst r1..r7 with P always requesting
      for (int b = 1; b <= 7; b++) begin
         n = 0;
         do begin
            cycle(0, 1, 3'd4, 16'h4444, 1, 3'(b), 16'hC000 + 16'(b), 1, b == 7, pa_, ia_);
            n++;
         end while (!ia_ && n < 10);
         chk("burst_beat_acc", int'(ia_), 1);
         if (b >= 2) chk("burst_locked", int'(locked), 1);
      end
      cycle(0, 1, 3'd4, 16'h4444, 0, 0, 0, 0, 0, pa_, ia_);
      chk("after_burst_p_acc", int'(pa_), 1);

      // Abort: enter lock, then drop i_lock with no beat
      cycle(0, 0, 0, 0, 1, 3'd6, 16'h6666, 1, 0, pa_, ia_);
      cycle(0, 1, 3'd1, 16'h1111, 0, 0, 0, 0, 0, pa_, ia_);
      chk("abort_p_blocked", int'(pa_), 0);
      cycle(0, 1, 3'd1, 16'h1111, 0, 0, 0, 0, 0, pa_, ia_);
      chk("abort_p_acc", int'(pa_), 1);

      // Reset while locked with a beat presented
      cycle(0, 0, 0, 0, 1, 3'd7, 16'h7777, 1, 0, pa_, ia_);
      cycle(1, 0, 0, 0, 1, 3'd3, 16'h3333, 1, 0, pa_, ia_);
      @(posedge clk); #2;
      chk("rst_lock_rf_we", int'(rf_we), 0);
      chk("rst_lock_locked", int'(locked), 0);
      chk("rst_lock_rf_data", int'(rf_data), 0);

      // Random traffic under the hold-until-accepted protocol
      p_pend = 0; i_pend = 0; i_bl = 0;
      pv = 0; iv = 0; il = 0; ilst = 0; pa = 0; ia = 0; pd = 0; id = 0;
      for (int k = 0; k < 3000; k++) begin
         r = ($urandom % 600 == 0);
         if (!p_pend) begin
            pv = ($urandom % 3 != 0);
            pa = 3'($urandom);
            pd = 16'($urandom);
         end
         if (!i_pend) begin
            if (i_bl > 0) begin
               if ($urandom % 20 == 0) begin
                  i_bl = 0; iv = 0; il = 0; ilst = 0;
               end else begin
                  iv = ($urandom % 4 != 0); il = 1; ilst = (i_bl == 1);
                  ia = 3'($urandom); id = 16'($urandom);
               end
            end else begin
               iv = ($urandom % 5 < 2);
               il = iv && ($urandom % 3 == 0);
               if (il) i_bl = 1 + int'($urandom % 4);
               ilst = il && (i_bl == 1);
               ia = 3'($urandom); id = 16'($urandom);
            end
         end
         cycle(r, pv, pa, pd, iv, ia, id, il, ilst, pa_, ia_);
         if (r) begin
            p_pend = 0; i_pend = 0; i_bl = 0;
         end else begin
            p_pend = pv && !pa_;
            if (iv && ia_) begin
               i_pend = 0;
               if (il && i_bl > 0) i_bl--;
            end else begin
               i_pend = iv;
            end
         end
      end
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, pa_, ia_);
      @(posedge clk); #3;
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
